uart_transmitter_controller: RTL

Downstream stage of the UART receive-side command controller in the system controller. It captures register-file read data and ALU results produced by the commands that controller issues. It serialises them into byte frames for the UART transmitter through a valid/busy handshake. Register-file reads produce one frame; ALU results produce RESULT_WIDTH/DATA_WIDTH frames, least-significant byte first.

---
 rtl/uart_transmitter_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_transmitter_controller.sv
// Captures register-file read data and ALU results into two slots and serialises them
// as byte frames to a UART transmitter through a valid/busy handshake.
module uart_transmitter_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int RESULT_WIDTH   = 16,
    parameter int ACCEPT_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   register_file_read_data,
    input  logic                    register_file_read_data_valid,
    input  logic [RESULT_WIDTH-1:0] ALU_result,
    input  logic                    ALU_result_valid,
    input  logic                    transmitter_busy,
    output logic [DATA_WIDTH-1:0]   transmitter_parallel_data,
    output logic                    transmitter_parallel_data_valid,
    output logic                    controller_busy,
    output logic                    overflow
);

    localparam int NUM_BYTES = RESULT_WIDTH / DATA_WIDTH;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMO_W     = $clog2(ACCEPT_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACCEPT, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sel_alu_q, sel_alu_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    alu_pend_q, alu_pend_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [RESULT_WIDTH-1:0] alu_data_q, alu_data_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   cur_byte;
    logic                    last_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_alu_q  <= 1'b0;
            idx_q      <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            alu_pend_q <= 1'b0;
            rd_data_q  <= '0;
            alu_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_alu_q  <= sel_alu_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rd_pend_q  <= rd_pend_d;
            alu_pend_q <= alu_pend_d;
            rd_data_q  <= rd_data_d;
            alu_data_q <= alu_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cur_byte  = sel_alu_q ? alu_data_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] : rd_data_q;
    assign last_byte = !sel_alu_q || (idx_q == IDX_W'(NUM_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        sel_alu_d  = sel_alu_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        rd_pend_d  = rd_pend_q;
        alu_pend_d = alu_pend_q;
        rd_data_d  = rd_data_q;
        alu_data_d = alu_data_q;
        ovf_d      = ovf_q;

        // A slot stays pending until its last byte completes, so pending alone marks it occupied.
        if (register_file_read_data_valid) begin
            if (!rd_pend_q) begin
                rd_data_d = register_file_read_data;
                rd_pend_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (ALU_result_valid) begin
            if (!alu_pend_q) begin
                alu_data_d = ALU_result;
                alu_pend_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rd_pend_q || alu_pend_q) begin
                    sel_alu_d = !rd_pend_q;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!transmitter_busy) begin
                    tx_data_d  = cur_byte;
                    tx_valid_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (transmitter_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_W'(ACCEPT_TIMEOUT - 1)) begin
                    state_d = SEND;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!transmitter_busy) begin
                    if (last_byte) begin
                        if (sel_alu_q) alu_pend_d = 1'b0;
                        else           rd_pend_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign transmitter_parallel_data       = tx_data_q;
    assign transmitter_parallel_data_valid = tx_valid_q;
    assign controller_busy                 = rd_pend_q || alu_pend_q || (state_q != IDLE);
    assign overflow                        = ovf_q;

endmodule
